traversal_chunked: RTL
======================

# traversal_chunked

Clocked, parametrised successor to the bitwise array traversal block. Captures a `Width`-bit word on a start request and presents it one `Chunk`-bit beat at a time, high-to-low or low-to-high. Beats are exchanged over a four-phase per-beat handshake (`reqDo`/`doFin`), and an overall `req`/`fin` handshake brackets the whole traversal. Adds a beat index, a last-beat flag and an abort path. Sits between a word-wide producer and a narrow serial consumer inside the flow-control layer.

## Interface
- `Width`, default 32: bits in the traversed word.
- `Chunk`, default 1: bits per beat.
  - Must divide `Width`; any other value is illegal.
  - Beats = `Width`/`Chunk`.
- `Direction`, default 0:
  - 0 = most-significant beat first.
  - 1 = least-significant beat first.
- Derived `IndexW` = max(1, clog2(Beats)).

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rstN`  in  1  asynchronous, active-low reset.
- `req`  in  1  start request (level).
- `fin`  out  1  traversal complete/aborted (level).
- `reqDo`  in  1  consumer acknowledge of the current beat.
- `doFin`  out  1  current beat valid on `dataOut`.
- `abort`  in  1  terminate the current traversal.
- `dataIn`  in  `Width`  word to traverse; sampled only at start.
- `dataOut`  out  `Chunk`  current beat.
- `index`  out  `IndexW`  number of the current beat, 0..Beats-1.
- `last`  out  1  high while `doFin`=1 and `index`=Beats-1.
- `aborted`  out  1  with `fin`=1: traversal ended by `abort`.

## Operation
- States: IDLE, OFFER, WAITLOW, DONE.
- IDLE:
  - Outputs: `fin`=0, `doFin`=0.
  - If `req`=1 on an edge: load `dataIn` into the internal shift register, set `index`=0, go to OFFER.
- OFFER:
  - Outputs: `doFin`=1, `dataOut`=current beat.
  - If `reqDo`=1 and `index`=Beats-1: go to DONE (`fin`=1).
  - If `reqDo`=1 and `index`<Beats-1: go to WAITLOW with `doFin`=0.
- WAITLOW:
  - `doFin`=0.
  - When `reqDo`=0 on an edge: shift the register by `Chunk`, `index`+1, go to OFFER.
- DONE:
  - `fin`=1 is held until `req`=0 on an edge.
  - On that edge go to IDLE: `fin`=0, `aborted`=0.
- Beat selection (k = `index`):
  - `Direction`=0: `dataOut`=`dataIn`[Width-1-k·Chunk -: Chunk].
  - `Direction`=1: `dataOut`=`dataIn`[k·Chunk +: Chunk].
  - Bit order within a beat is unchanged.
- `dataOut` and `index` hold their last values outside OFFER.
  - They are meaningful only while `doFin`=1.
- `abort`=1 in OFFER or WAITLOW:
  - Next state DONE with `doFin`=0, `fin`=1, `aborted`=1.
  - Abort takes priority over `reqDo` in the same cycle; that beat does not count as accepted.
- `abort` is ignored in IDLE and DONE.
  - `abort`=1 with `req`=1 in IDLE: the start still happens.
- `dataIn` changes after the start edge have no effect.
- Beats=1 (`Chunk`=`Width`): OFFER → DONE on the first acknowledge; WAITLOW is never entered.

## Timing
- Reset (`rstN`=0, asynchronous):
  - State IDLE.
  - `fin`=0, `doFin`=0, `last`=0, `aborted`=0.
  - `dataOut`=0, `index`=0, shift register cleared.
- Reset mid-traversal aborts silently: no `fin` is produced.
  - If `req` is still 1 after release, a new traversal starts on the first edge.
- All outputs are registered, except `last`.
  - `last` is decoded from the registered `doFin` and `index`.
- Start latency: `req` sampled 1 at edge N → `doFin`=1 with beat 0 after edge N.
- Per-beat acknowledge:
  - `reqDo` sampled 1 at edge M → `doFin`=0 after edge M.
  - `reqDo` sampled 0 at edge P>M → next beat with `doFin`=1 after edge P.
  - Minimum 2 cycles per beat.
- Completion: the final acknowledge at edge M → `fin`=1 after edge M.
  - `doFin` does not pulse again.
- Abort latency: one edge; `fin`/`aborted` rise and `doFin` falls together.
- Release: `req` sampled 0 in DONE → `fin`=0 after that edge.
  - A new start requires `req` to return high, earliest on the next edge.

## Test plan
- Defaults (32/1/0), `dataIn`=0x8000_0001, consumer acknowledges each beat after 1 cycle:
  - 32 beats with `dataOut`=1,0×30,1.
  - `index` runs 0..31; `last` only on beat 31.
  - `fin`=1 after the 32nd acknowledge; `aborted`=0.
- `Width`=16, `Chunk`=4, `Direction`=1, `dataIn`=0xA5C3: beats 0x3, 0xC, 0x5, 0xA.
  - Repeat with `Direction`=0: 0xA, 0x5, 0xC, 0x3.
- `Chunk`=`Width`=8, `dataIn`=0x5A:
  - One beat 0x5A with `last`=1.
  - `fin` after the first acknowledge; WAITLOW never entered.
- `abort` asserted together with `reqDo` on beat 5 of 32:
  - Next cycle `doFin`=0, `fin`=1, `aborted`=1, `index`=5.
  - Dropping `req` clears `fin`/`aborted`.
- Change `dataIn` mid-traversal and hold `reqDo` high for 3 cycles:
  - Output beats come from the captured word.
  - The next beat appears only after `reqDo` falls.
- Assert `rstN`=0 mid-traversal with `req` held 1:
  - All outputs are 0 immediately.
  - After release, a fresh traversal of the current `dataIn` starts with `index`=0.

Source files
------------

// File: rtl/traversal_chunked_if.sv
// Bundle for the traversal block: the overall req/fin handshake, the per-beat
// reqDo/doFin handshake, the abort path, the captured word and the beat outputs.
// master = producer/consumer side, slave = traversal block.
interface traversal_chunked_if #(
  parameter int Width = 32,
  parameter int Chunk = 1
);
  localparam int Beats  = Width / Chunk;
  localparam int IndexW = (Beats > 1) ? $clog2(Beats) : 1;

  logic              req;
  logic              fin;
  logic              reqDo;
  logic              doFin;
  logic              abort;
  logic [Width-1:0]  dataIn;
  logic [Chunk-1:0]  dataOut;
  logic [IndexW-1:0] index;
  logic              last;
  logic              aborted;

  modport master (
    output req, reqDo, abort, dataIn,
    input  fin, doFin, dataOut, index, last, aborted
  );

  modport slave (
    input  req, reqDo, abort, dataIn,
    output fin, doFin, dataOut, index, last, aborted
  );
endinterface

// File: rtl/traversal_chunked.sv
// Chunked word traversal: captures a Width-bit word on req and offers it one
// Chunk-bit beat at a time over a four-phase reqDo/doFin handshake, MSB-beat
// first (Direction=0) or LSB-beat first (Direction=1). An abort in OFFER or
// WAITLOW ends the traversal with fin and aborted raised together.
// All outputs are registered except last, which is decoded from doFin/index.
module traversal_chunked #(
  parameter int Width     = 32,
  parameter int Chunk     = 1,
  parameter int Direction = 0
) (
  input logic                clk,
  input logic                rstN,
  traversal_chunked_if.slave bus
);

  localparam int Beats  = Width / Chunk;
  localparam int IndexW = (Beats > 1) ? $clog2(Beats) : 1;
  localparam logic [IndexW-1:0] LastIdx = IndexW'(Beats - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OFFER   = 2'd1,
    WAITLOW = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t            state_r,    state_s;
  logic [Width-1:0]  shift_r,    shift_s;
  logic [IndexW-1:0] index_r,    index_s;
  logic [Chunk-1:0]  data_out_r, data_out_s;
  logic              do_fin_r,   do_fin_s;
  logic              fin_r,      fin_s;
  logic              aborted_r,  aborted_s;
  logic [Width-1:0]  shifted_s;

  // The beat that leaves next always sits at the outgoing end of the register.
  function automatic logic [Chunk-1:0] head_beat(input logic [Width-1:0] word);
    if (Direction == 0) begin
      head_beat = word[Width-1 -: Chunk];
    end else begin
      head_beat = word[Chunk-1:0];
    end
  endfunction

  // Drop the beat just accepted so the following one reaches the outgoing end.
  function automatic logic [Width-1:0] shift_word(input logic [Width-1:0] word);
    if (Direction == 0) begin
      shift_word = word << Chunk;
    end else begin
      shift_word = word >> Chunk;
    end
  endfunction

  assign shifted_s = shift_word(shift_r);

  // Next-state and next-output decode; every register holds unless a branch moves it.
  always_comb begin
    state_s    = state_r;
    shift_s    = shift_r;
    index_s    = index_r;
    data_out_s = data_out_r;
    do_fin_s   = do_fin_r;
    fin_s      = fin_r;
    aborted_s  = aborted_r;
    case (state_r)
      IDLE: begin
        do_fin_s  = 1'b0;
        fin_s     = 1'b0;
        aborted_s = 1'b0;
        if (bus.req) begin
          // abort is ignored here: a start always wins in IDLE
          shift_s    = bus.dataIn;
          index_s    = '0;
          data_out_s = head_beat(bus.dataIn);
          do_fin_s   = 1'b1;
          state_s    = OFFER;
        end else begin
          state_s = IDLE;
        end
      end
      OFFER: begin
        if (bus.abort) begin
          // abort outranks a simultaneous acknowledge; that beat is not accepted
          do_fin_s  = 1'b0;
          fin_s     = 1'b1;
          aborted_s = 1'b1;
          state_s   = DONE;
        end else if (bus.reqDo) begin
          do_fin_s = 1'b0;
          if (index_r == LastIdx) begin
            fin_s     = 1'b1;
            aborted_s = 1'b0;
            state_s   = DONE;
          end else begin
            state_s = WAITLOW;
          end
        end else begin
          do_fin_s = 1'b1;
        end
      end
      WAITLOW: begin
        if (bus.abort) begin
          do_fin_s  = 1'b0;
          fin_s     = 1'b1;
          aborted_s = 1'b1;
          state_s   = DONE;
        end else if (!bus.reqDo) begin
          shift_s    = shifted_s;
          index_s    = index_r + IndexW'(1);
          data_out_s = head_beat(shifted_s);
          do_fin_s   = 1'b1;
          state_s    = OFFER;
        end else begin
          do_fin_s = 1'b0;
        end
      end
      DONE: begin
        do_fin_s = 1'b0;
        if (!bus.req) begin
          fin_s     = 1'b0;
          aborted_s = 1'b0;
          state_s   = IDLE;
        end else begin
          fin_s = 1'b1;
        end
      end
      default: begin
        do_fin_s  = 1'b0;
        fin_s     = 1'b0;
        aborted_s = 1'b0;
        state_s   = IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything and drops any traversal silently.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_r    <= IDLE;
      shift_r    <= '0;
      index_r    <= '0;
      data_out_r <= '0;
      do_fin_r   <= 1'b0;
      fin_r      <= 1'b0;
      aborted_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      shift_r    <= shift_s;
      index_r    <= index_s;
      data_out_r <= data_out_s;
      do_fin_r   <= do_fin_s;
      fin_r      <= fin_s;
      aborted_r  <= aborted_s;
    end
  end

  assign bus.fin     = fin_r;
  assign bus.doFin   = do_fin_r;
  assign bus.dataOut = data_out_r;
  assign bus.index   = index_r;
  assign bus.aborted = aborted_r;
  assign bus.last    = do_fin_r & (index_r == LastIdx);

endmodule
